// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared fetch-side types: widths, the NOP encoding, FSM states and next-PC selects.
// The range helper is common to fetch issue and the loader write path.
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        LOAD = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_RESET  = 2'd3
    } pc_sel_t;

    function automatic logic addr_in_range(input logic [PC_W-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Pipeline, loader and instruction-memory signals of the fetch controller.
// master is the controller side, slave is the surrounding pipeline/memory/loader.
interface instr_fetch_ctrl_if;

    logic                        start;
    logic                        halt_req;
    logic                        stall;
    logic                        br_taken;
    logic [cpu_pkg::PC_W-1:0]    br_target;

    logic                        ld_valid;
    logic                        ld_last;
    logic [cpu_pkg::PC_W-1:0]    ld_addr;
    logic [cpu_pkg::INSTR_W-1:0] ld_data;
    logic                        ld_ready;

    logic                        imem_en;
    logic                        imem_we;
    logic [cpu_pkg::PC_W-1:0]    imem_addr;
    logic [cpu_pkg::INSTR_W-1:0] imem_wdata;
    logic [cpu_pkg::INSTR_W-1:0] imem_rdata;

    logic [cpu_pkg::INSTR_W-1:0] instr_out;
    logic                        instr_valid;
    logic [cpu_pkg::PC_W-1:0]    pc_out;
    logic [1:0]                  state_out;
    logic                        addr_err;
    logic [31:0]                 perf_fetch;
    logic [31:0]                 perf_squash;

    modport master (
        input  start, halt_req, stall, br_taken, br_target,
        input  ld_valid, ld_last, ld_addr, ld_data,
        input  imem_rdata,
        output ld_ready, imem_en, imem_we, imem_addr, imem_wdata,
        output instr_out, instr_valid, pc_out, state_out, addr_err,
        output perf_fetch, perf_squash
    );

    modport slave (
        output start, halt_req, stall, br_taken, br_target,
        output ld_valid, ld_last, ld_addr, ld_data,
        output imem_rdata,
        input  ld_ready, imem_en, imem_we, imem_addr, imem_wdata,
        input  instr_out, instr_valid, pc_out, state_out, addr_err,
        input  perf_fetch, perf_squash
    );

endinterface

// File: rtl/instr_fetch_ctrl_pc_next.sv
// Combinational next-PC select (hold / +1 / branch / restart) and issue range check.
// Purely combinational; no wrap past DEPTH because an out-of-range PC is never issued.
module fetch_pc_next
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 100,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc_nxt,
    output logic            pc_ok
);

    always_comb begin
        pc_nxt = pc;
        case (sel)
            PC_INC:    pc_nxt = pc + PC_W'(1);
            PC_BRANCH: pc_nxt = br_target;
            PC_RESET:  pc_nxt = RESET_PC;
            default:   pc_nxt = pc;
        endcase
    end

    assign pc_ok = addr_in_range(pc, DEPTH);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: read issued at pc appears on instr_out the next cycle; stall freezes fetch.
// Loader beats are accepted only in LOAD; INSTR_FETCH_PERF_EN enables the perf counters.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 100,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_ctrl_if.master bus
);

    fetch_state_t       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_nxt;
    logic               pc_ok;
    pc_sel_t            pc_sel;

    logic [PC_W-1:0]    pc_out_q;
    logic               valid_q;
    logic               fresh_q;
    logic [INSTR_W-1:0] instr_hold;
    logic [INSTR_W-1:0] instr_mux;
    logic               addr_err_q;

    logic               run;
    logic               issue;
    logic               beat;
    logic               wr_ok;
    logic               squash;

    assign run    = (state == RUN);
    assign issue  = run && !bus.halt_req && !bus.stall && pc_ok;
    assign squash = run && (bus.halt_req || bus.br_taken);
    assign beat   = (state == LOAD) && bus.ld_valid;
    assign wr_ok  = beat && addr_in_range(bus.ld_addr, DEPTH);

    // Memory port is muxed combinationally so writes land in the accepting cycle
    // and an asynchronous reset kills a pending write immediately.
    assign bus.ld_ready   = beat;
    assign bus.imem_en    = issue;
    assign bus.imem_we    = wr_ok;
    assign bus.imem_addr  = wr_ok ? bus.ld_addr : (issue ? pc : '0);
    assign bus.imem_wdata = wr_ok ? bus.ld_data : '0;

    // Fresh read data passes straight through; the holding copy covers stalls and squashes.
    assign instr_mux       = fresh_q ? bus.imem_rdata : instr_hold;
    assign bus.instr_out   = instr_mux;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.state_out   = state;
    assign bus.addr_err    = addr_err_q;

    always_comb begin
        pc_sel = PC_HOLD;
        case (state)
            IDLE, HALT: begin
                if (!bus.ld_valid && bus.start) pc_sel = PC_RESET;
            end
            RUN: begin
                if (bus.halt_req)      pc_sel = PC_HOLD;
                else if (bus.br_taken) pc_sel = PC_BRANCH;
                else if (issue)        pc_sel = PC_INC;
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

    fetch_pc_next #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .sel       (pc_sel),
        .pc        (pc),
        .br_target (bus.br_target),
        .pc_nxt    (pc_nxt),
        .pc_ok     (pc_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
            fresh_q    <= 1'b0;
            instr_hold <= NOP_INSTR;
            addr_err_q <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            fresh_q    <= issue;
            instr_hold <= instr_mux;
            case (state)
                IDLE, HALT: begin
                    if (bus.ld_valid)   state <= LOAD;
                    else if (bus.start) state <= RUN;
                end
                LOAD: begin
                    if (beat) begin
                        if (!wr_ok)      addr_err_q <= 1'b1;
                        if (bus.ld_last) state      <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state   <= HALT;
                        valid_q <= 1'b0;
                    end else if (bus.br_taken) begin
                        valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        if (!pc_ok) begin
                            addr_err_q <= 1'b1;
                            state      <= HALT;
                            valid_q    <= 1'b0;
                        end else begin
                            valid_q  <= 1'b1;
                            pc_out_q <= pc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (valid_q && fresh_q && fetch_cnt != '1) fetch_cnt  <= fetch_cnt + 32'd1;
            if (squash && squash_cnt != '1)            squash_cnt <= squash_cnt + 32'd1;
        end
    end

    assign bus.perf_fetch  = fetch_cnt;
    assign bus.perf_squash = squash_cnt;
`else
    logic unused_squash;
    assign unused_squash   = squash;
    assign bus.perf_fetch  = '0;
    assign bus.perf_squash = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural instruction memory and a delivery scoreboard.
module tb_instr_fetch_ctrl;
    import cpu_pkg::*;

    localparam int DEPTH = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(10'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    int n_pop    = 0;
    bit bad_fetch = 0;
    logic stall_q = 1'b0;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int a, input int b);
        for (int i = a; i <= b; i++) sb.push_back('{pc: 10'(i), ins: ref_mem[i]});
    endtask

    always @(posedge clk) stall_q <= bus.stall;

    // A delivery is new unless the previous cycle was a stall that froze the outputs.
    always @(negedge clk) begin
        if (bus.imem_en && int'(bus.imem_addr) >= DEPTH) bad_fetch = 1;
        if (!reset && bus.instr_valid && !stall_q) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pc", 32'(bus.pc_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                check($sformatf("sb_pc%0d", e.pc), 32'(bus.pc_out), 32'(e.pc));
                check($sformatf("sb_instr%0d", e.pc), bus.instr_out, e.ins);
            end
        end
    end

    task automatic check_reset(input string p);
        check({p, "_state"},       32'(bus.state_out),   32'd0);
        check({p, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        check({p, "_instr_out"},   bus.instr_out,        32'd0);
        check({p, "_pc_out"},      32'(bus.pc_out),      32'd0);
        check({p, "_imem_en"},     32'(bus.imem_en),     32'd0);
        check({p, "_imem_we"},     32'(bus.imem_we),     32'd0);
        check({p, "_imem_addr"},   32'(bus.imem_addr),   32'd0);
        check({p, "_imem_wdata"},  bus.imem_wdata,       32'd0);
        check({p, "_ld_ready"},    32'(bus.ld_ready),    32'd0);
        check({p, "_addr_err"},    32'(bus.addr_err),    32'd0);
        check({p, "_perf_fetch"},  bus.perf_fetch,       32'd0);
        check({p, "_perf_squash"}, bus.perf_squash,      32'd0);
    endtask

    task automatic load_beat(input logic [9:0] a, input logic [31:0] d, input logic last);
        bit got = 0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (bus.ld_ready) begin
                got = 1;
                break;
            end
            cyc();
            #1;
        end
        check($sformatf("ld_accept%0d", a), 32'(got), 32'd1);
        check($sformatf("ld_we%0d", a), 32'(bus.imem_we), 32'(int'(a) < DEPTH));
        if (int'(a) < DEPTH) begin
            check($sformatf("ld_addr%0d", a), 32'(bus.imem_addr), 32'(a));
            check($sformatf("ld_wdata%0d", a), bus.imem_wdata, d);
            ref_mem[a] = d;
        end
        cyc();
    endtask

    task automatic wait_pc(input logic [9:0] target, input int budget);
        bit got = 0;
        for (int k = 0; k < budget; k++) begin
            cyc();
            #1;
            if (bus.instr_valid && bus.pc_out == target) begin
                got = 1;
                break;
            end
        end
        check($sformatf("wait_pc%0d", target), 32'(got), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        bus.start = 0; bus.halt_req = 0; bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.ld_valid = 0; bus.ld_last = 0; bus.ld_addr = '0; bus.ld_data = '0;

        #12;
        check_reset("por");
        cyc();
        reset = 1'b0;

        // Program load, first beat presented in IDLE.
        load_beat(10'd0, 32'h0000_0000, 1'b0);
        load_beat(10'd1, 32'h0802_0005, 1'b0);
        load_beat(10'd2, 32'h5802_0001, 1'b0);
        load_beat(10'd3, 32'h0000_0000, 1'b1);
        bus.ld_valid = 0; bus.ld_last = 0;
        #1;
        check("load_done_state", 32'(bus.state_out), 32'd0);

        // Run; loader beats offered during RUN must be ignored.
        bus.start = 1;
        push_range(0, 4);
        cyc();
        bus.start = 0;
        bus.ld_valid = 1; bus.ld_addr = 10'd50; bus.ld_data = 32'hFFFF_FFFF;
        #1;
        check("run_state", 32'(bus.state_out), 32'd1);
        check("run_first_en", 32'(bus.imem_en), 32'd1);
        check("run_first_addr", 32'(bus.imem_addr), 32'd0);
        check("run_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("run_ld_we", 32'(bus.imem_we), 32'd0);
        cyc();
        #1;
        check("run_ld_ready2", 32'(bus.ld_ready), 32'd0);
        check("run_addr2", 32'(bus.imem_addr), 32'd1);
        bus.ld_valid = 0;
        wait_pc(10'd4, 10);

        // Branch at pc_out=4: read of 5 is squashed, 9 follows.
        bus.br_taken = 1; bus.br_target = 10'd9;
        push_range(9, 12);
        #1;
        check("br_issue_addr", 32'(bus.imem_addr), 32'd5);
        cyc();
        bus.br_taken = 0;
        #1;
        check("br_squash_valid", 32'(bus.instr_valid), 32'd0);
        check("br_target_addr", 32'(bus.imem_addr), 32'd9);
        cyc();
        #1;
        check("br_pc_out", 32'(bus.pc_out), 32'd9);
        check("br_valid", 32'(bus.instr_valid), 32'd1);
        wait_pc(10'd12, 10);

        // halt_req + br_taken + stall together: halt wins.
        bus.halt_req = 1; bus.br_taken = 1; bus.br_target = 10'd30; bus.stall = 1;
        #1;
        check("prio_en", 32'(bus.imem_en), 32'd0);
        cyc();
        bus.halt_req = 0; bus.br_taken = 0; bus.stall = 0;
        #1;
        check("prio_state", 32'(bus.state_out), 32'd2);
        check("prio_valid", 32'(bus.instr_valid), 32'd0);
        check("prio_pc_out", 32'(bus.pc_out), 32'd12);
        cyc();
        #1;
        check("halt_en", 32'(bus.imem_en), 32'd0);
        check("halt_state", 32'(bus.state_out), 32'd2);

        // Restart from HALT; stall at pc_out=5, then run to the end of memory.
        bus.start = 1;
        push_range(0, 99);
        cyc();
        bus.start = 0;
        #1;
        check("restart_state", 32'(bus.state_out), 32'd1);
        check("restart_addr", 32'(bus.imem_addr), 32'd0);
        wait_pc(10'd5, 10);
        bus.stall = 1;
        #1;
        check("stall_en", 32'(bus.imem_en), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            check("stall_pc_hold", 32'(bus.pc_out), 32'd5);
            check("stall_instr_hold", bus.instr_out, ref_mem[5]);
            check("stall_valid_hold", 32'(bus.instr_valid), 32'd1);
            check("stall_en_hold", 32'(bus.imem_en), 32'd0);
        end
        cyc();
        bus.stall = 0;
        #1;
        check("unstall_addr", 32'(bus.imem_addr), 32'd6);
        wait_pc(10'd6, 3);
        wait_pc(10'd99, 150);
        check("end_no_fetch100", 32'(bus.imem_en), 32'd0);
        check("end_err_before", 32'(bus.addr_err), 32'd0);
        cyc();
        #1;
        check("end_addr_err", 32'(bus.addr_err), 32'd1);
        check("end_state", 32'(bus.state_out), 32'd2);
        check("end_valid", 32'(bus.instr_valid), 32'd0);
        check("end_bad_fetch", 32'(bad_fetch), 32'd0);
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        check("run_no_ld_write", mem[50], 32'hA500_0032);
`ifdef INSTR_FETCH_PERF_EN
        check("perf_fetch", bus.perf_fetch, 32'(n_pop));
        check("perf_squash", bus.perf_squash, 32'd2);
`else
        check("perf_fetch_off", bus.perf_fetch, 32'd0);
        check("perf_squash_off", bus.perf_squash, 32'd0);
`endif

        reset = 1;
        #1;
        check("rst_state", 32'(bus.state_out), 32'd0);
        check("rst_addr_err", 32'(bus.addr_err), 32'd0);
        cyc();
        reset = 0;

        // Out-of-range loader beat: accepted, no write, sticky error.
        bus.ld_valid = 1; bus.ld_addr = 10'd120; bus.ld_data = 32'h0000_1234; bus.ld_last = 0;
        #1;
        check("oor_idle_ready", 32'(bus.ld_ready), 32'd0);
        cyc();
        #1;
        check("oor_ready", 32'(bus.ld_ready), 32'd1);
        check("oor_we", 32'(bus.imem_we), 32'd0);
        cyc();
        bus.ld_addr = 10'd7; bus.ld_data = 32'hDEAD_BEEF;
        #1;
        check("oor_addr_err", 32'(bus.addr_err), 32'd1);
        check("mid_state", 32'(bus.state_out), 32'd3);
        check("mid_we", 32'(bus.imem_we), 32'd1);
        check("mid_addr", 32'(bus.imem_addr), 32'd7);
        check("mid_wdata", bus.imem_wdata, 32'hDEAD_BEEF);

        // Reset in the middle of a write beat.
        reset = 1;
        #1;
        check_reset("rst_mid");
        cyc();
        #1;
        check("rst_mid_no_write", mem[7], 32'hA500_0007);
        bus.ld_valid = 0;
        reset = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
